// File: rtl/alu_pkg.sv
// Shared widths and FSM encoding for the ALU operand-fetch / issue / writeback stage.
package alu_pkg;

    localparam int OP_W    = 4;
    localparam int DATA_W  = 8;
    localparam int FLAG_W  = 4;
    localparam int RADDR_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// NREGS x DATA_W register file: r0 reads as zero, two operand read ports, a debug port,
// one synchronous write port with synchronous clear.
module regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [RADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0]  rdata_a,
    input  logic [RADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]  rdata_b,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    logic [DATA_W-1:0] mem [NREGS];

    // NOTE: the storage is cleared on reset because the architecture promises all-zero
    // registers after reset; this forces flops rather than a RAM macro, which is fine at 8x8.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = (raddr_a  == '0) ? '0 : mem[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : mem[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Operand fetch, issue and writeback around an external fixed-latency 8-bit ALU.
// One instruction in flight; next acceptance only after the writeback edge.
module alu_issue
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int NREGS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OP_W-1:0]    instr_op,
    input  logic [RADDR_W-1:0] instr_rd,
    input  logic [RADDR_W-1:0] instr_rs,
    input  logic [RADDR_W-1:0] instr_rt,
    input  logic [DATA_W-1:0]  instr_imm,
    input  logic               instr_use_imm,
    input  logic               instr_setf,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [FLAG_W-1:0]  flags,
    output logic               done,
    input  logic [RADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam logic [1:0] LAT_M1 = 2'(ALU_LAT - 1);

    state_e               state;
    logic [1:0]           cnt;
    logic [RADDR_W-1:0]   rd_q;
    logic                 setf_q;
    logic [DATA_W-1:0]    rs_data;
    logic [DATA_W-1:0]    rt_data;
    logic                 wb_en;

    regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_en),
        .waddr    (rd_q),
        .wdata    (alu_out),
        .raddr_a  (instr_rs),
        .rdata_a  (rs_data),
        .raddr_b  (instr_rt),
        .rdata_b  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Gated by rst so a reset landing in WB aborts the write and suppresses done.
    assign instr_ready = (state == IDLE) && !rst;
    assign wb_en       = (state == WB) && !rst;
    assign done        = wb_en;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make the update order matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            rd_q   <= '0;
            setf_q <= 1'b0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_a  <= rs_data;
                        alu_b  <= instr_use_imm ? instr_imm : rt_data;
                        alu_op <= instr_op;
                        rd_q   <= instr_rd;
                        setf_q <= instr_setf;
                        cnt    <= LAT_M1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) state <= WB;
                    else           cnt   <= cnt - 2'd1;
                end
                WB: begin
                    if (setf_q) flags <= alu_flags;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench: two DUTs (ALU_LAT = 1 and 4), each with its own clocked ALU stub,
// checked against a register/flag reference model.
module tb_alu_issue;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [7:0] imm;
        logic       use_imm;
        logic       setf;
    } ins_t;

    logic       clk;
    logic       rst           [2];
    logic       instr_valid   [2];
    logic       instr_ready   [2];
    logic [3:0] instr_op      [2];
    logic [2:0] instr_rd      [2];
    logic [2:0] instr_rs      [2];
    logic [2:0] instr_rt      [2];
    logic [7:0] instr_imm     [2];
    logic       instr_use_imm [2];
    logic       instr_setf    [2];
    logic [7:0] alu_a         [2];
    logic [7:0] alu_b         [2];
    logic [3:0] alu_op        [2];
    logic [7:0] alu_out       [2];
    logic [3:0] alu_flags     [2];
    logic [3:0] flags         [2];
    logic       done          [2];
    logic [2:0] dbg_addr      [2];
    logic [7:0] dbg_data      [2];

    logic [3:0] stub_flags [2];
    logic       ovr        [2];

    logic [7:0] model_reg   [2][8];
    logic [3:0] model_flags [2];
    int         last_acc    [2];

    int passed = 0;
    int total  = 0;
    int cyc_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a & b;
            4'h3:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [7:0] pipe [4];

        alu_issue #(.ALU_LAT(LAT), .NREGS(8)) u_dut (
            .clk           (clk),
            .rst           (rst[g]),
            .instr_valid   (instr_valid[g]),
            .instr_ready   (instr_ready[g]),
            .instr_op      (instr_op[g]),
            .instr_rd      (instr_rd[g]),
            .instr_rs      (instr_rs[g]),
            .instr_rt      (instr_rt[g]),
            .instr_imm     (instr_imm[g]),
            .instr_use_imm (instr_use_imm[g]),
            .instr_setf    (instr_setf[g]),
            .alu_a         (alu_a[g]),
            .alu_b         (alu_b[g]),
            .alu_op        (alu_op[g]),
            .alu_out       (alu_out[g]),
            .alu_flags     (alu_flags[g]),
            .flags         (flags[g]),
            .done          (done[g]),
            .dbg_addr      (dbg_addr[g]),
            .dbg_data      (dbg_data[g])
        );

        // ALU stub: result of the current operands appears LAT clocks later.
        always @(posedge clk) begin
            pipe[0] <= alu_fn(alu_op[g], alu_a[g], alu_b[g]);
            for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
        end
        assign alu_out[g]   = ovr[g] ? 8'hFF : pipe[LAT-1];
        assign alu_flags[g] = stub_flags[g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ins_t mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                input logic [2:0] rt, input logic [7:0] imm, input logic use_imm,
                                input logic setf);
        ins_t i;
        i.op = op; i.rd = rd; i.rs = rs; i.rt = rt; i.imm = imm; i.use_imm = use_imm; i.setf = setf;
        return i;
    endfunction

    task automatic drive(input int d, input ins_t i);
        instr_op[d]      = i.op;
        instr_rd[d]      = i.rd;
        instr_rs[d]      = i.rs;
        instr_rt[d]      = i.rt;
        instr_imm[d]     = i.imm;
        instr_use_imm[d] = i.use_imm;
        instr_setf[d]    = i.setf;
        instr_valid[d]   = 1'b1;
    endtask

    task automatic dbg_read(input int d, input logic [2:0] addr, output logic [7:0] data);
        dbg_addr[d] = addr;
        #1;
        data = dbg_data[d];
    endtask

    task automatic clear_model(input int d);
        for (int r = 0; r < 8; r++) model_reg[d][r] = 8'h00;
        model_flags[d] = 4'h0;
    endtask

    task automatic do_reset(input int d);
        logic [7:0] v;
        rst[d] = 1'b1;
        instr_valid[d] = 1'b0;
        @(negedge clk);
        check("ready_in_reset", instr_ready[d], 1'b0);
        @(negedge clk);
        check("reset_alu_a", alu_a[d], 8'h00);
        check("reset_alu_b", alu_b[d], 8'h00);
        check("reset_alu_op", alu_op[d], 4'h0);
        check("reset_flags", flags[d], 4'h0);
        check("reset_done", done[d], 1'b0);
        rst[d] = 1'b0;
        clear_model(d);
        #1;
        check("ready_after_reset", instr_ready[d], 1'b1);
        for (int r = 0; r < 8; r++) begin
            dbg_read(d, 3'(r), v);
            check("reset_reg", v, 8'h00);
        end
        @(negedge clk);
    endtask

    // Starts at a negedge; returns one time unit after the negedge following the write edge.
    task automatic issue(input int d, input ins_t ins, input logic [3:0] fl, input bit override,
                         input bit chained_in, input bit chain_out, input ins_t nxt);
        int         lat = (d == 0) ? 1 : 4;
        int         n = 0;
        int         acc;
        logic [7:0] ea, eb, res, v;
        drive(d, ins);
        stub_flags[d] = fl;
        ovr[d]        = override;
        while (instr_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", instr_ready[d], 1'b1);
        ea  = model_reg[d][ins.rs];
        eb  = ins.use_imm ? ins.imm : model_reg[d][ins.rt];
        res = override ? 8'hFF : alu_fn(ins.op, ea, eb);
        @(posedge clk);
        @(negedge clk);
        acc = cyc_cnt;
        if (chained_in) check("issue_interval", acc - last_acc[d], lat + 2);
        last_acc[d] = acc;
        if (chain_out) drive(d, nxt);
        else           instr_valid[d] = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            if (c > 1) @(negedge clk);
            check("ready_busy", instr_ready[d], 1'b0);
            check("alu_a_stable", alu_a[d], ea);
            check("alu_b_stable", alu_b[d], eb);
            check("alu_op_stable", alu_op[d], ins.op);
            check("done_timing", done[d], (c == lat + 1) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        if (ins.rd != 3'd0) model_reg[d][ins.rd] = res;
        if (ins.setf) model_flags[d] = fl;
        check("done_after_wb", done[d], 1'b0);
        check("ready_after_wb", instr_ready[d], 1'b1);
        check("flags_after_wb", flags[d], model_flags[d]);
        dbg_read(d, ins.rd, v);
        check("writeback_data", v, model_reg[d][ins.rd]);
    endtask

    task automatic reset_mid_exec(input int d);
        int         lat = (d == 0) ? 1 : 4;
        logic [7:0] v;
        drive(d, mk(4'h0, 3'd5, 3'd1, 3'd0, 8'h33, 1'b1, 1'b1));
        stub_flags[d] = 4'hF;
        ovr[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        instr_valid[d] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            check("abort_done_exec", done[d], 1'b0);
            if (c == lat) rst[d] = 1'b1;
        end
        @(negedge clk);
        check("abort_done_rst", done[d], 1'b0);
        check("abort_ready_rst", instr_ready[d], 1'b0);
        check("abort_flags", flags[d], 4'h0);
        rst[d] = 1'b0;
        clear_model(d);
        @(negedge clk);
        check("abort_ready_after", instr_ready[d], 1'b1);
        check("abort_done_after", done[d], 1'b0);
        dbg_read(d, 3'd5, v);
        check("abort_r5", v, 8'h00);
    endtask

    task automatic run_suite(input int d);
        ins_t       none = '0;
        ins_t       i;
        logic [7:0] v;
        do_reset(d);
        issue(d, mk(4'h0, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b0), 4'h0, 1'b0, 1'b0, 1'b0, none);
        issue(d, mk(4'h0, 3'd2, 3'd1, 3'd0, 8'h03, 1'b1, 1'b0), 4'h0, 1'b0, 1'b0, 1'b0, none);
        dbg_read(d, 3'd2, v);
        check("r2_sum", v, 8'h08);
        issue(d, mk(4'h0, 3'd0, 3'd1, 3'd2, 8'h00, 1'b0, 1'b0), 4'h0, 1'b1, 1'b0, 1'b0, none);
        dbg_read(d, 3'd0, v);
        check("r0_zero", v, 8'h00);
        issue(d, mk(4'h0, 3'd3, 3'd0, 3'd0, 8'h7F, 1'b1, 1'b0), 4'h0, 1'b0, 1'b0, 1'b1,
              mk(4'h0, 3'd4, 3'd3, 3'd0, 8'h01, 1'b1, 1'b0));
        issue(d, mk(4'h0, 3'd4, 3'd3, 3'd0, 8'h01, 1'b1, 1'b0), 4'h0, 1'b0, 1'b1, 1'b0, none);
        dbg_read(d, 3'd4, v);
        check("r4_dependent", v, 8'h80);
        issue(d, mk(4'h1, 3'd6, 3'd4, 3'd1, 8'h00, 1'b0, 1'b1), 4'b1010, 1'b0, 1'b0, 1'b0, none);
        check("flags_set", flags[d], 4'b1010);
        issue(d, mk(4'h2, 3'd7, 3'd4, 3'd6, 8'h00, 1'b0, 1'b0), 4'b0101, 1'b0, 1'b0, 1'b0, none);
        check("flags_kept", flags[d], 4'b1010);
        for (int k = 0; k < 12; k++) begin
            i = mk(4'($urandom_range(0, 4)), 3'($urandom), 3'($urandom), 3'($urandom),
                   8'($urandom), 1'($urandom), 1'($urandom));
            issue(d, i, 4'($urandom), 1'b0, 1'b0, 1'b0, none);
        end
        for (int r = 0; r < 8; r++) begin
            dbg_read(d, 3'(r), v);
            check("final_regs", v, model_reg[d][r]);
        end
        @(negedge clk);
        reset_mid_exec(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            instr_valid[d] = 1'b0;
            drive(d, '0);
            instr_valid[d] = 1'b0;
            dbg_addr[d] = 3'd0;
            stub_flags[d] = 4'h0;
            ovr[d] = 1'b0;
            last_acc[d] = 0;
            clear_model(d);
        end
        @(negedge clk);
        run_suite(0);
        @(negedge clk);
        run_suite(1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
